// File: rtl/axis_insert_header_arbiter_pkg.sv
// Shared definitions for the header-inserter arbiter: state encoding and round-robin pick.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axis_insert_header_arbiter_pkg;

    // Packet FSM encoding, kept as plain constants so older tools can read it.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Widest requester vector the picker supports; narrower users zero-extend.
    localparam int MAX_SRC = 8;

    // First set bit of req at or after ptr, wrapping at n.
    // Returns {found, index[2:0]}; index is meaningless when found is 0.
    function automatic logic [3:0] rr_pick(
        input logic [MAX_SRC-1:0] req,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = 0; k < MAX_SRC; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !res[3] && req[idx[2:0]]) begin
                res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_insert_header_arbiter_rr_select.sv
// Combinational round-robin picker: request vector + start pointer -> winning index + found flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to latch the result.
// Ports: req_i (N requests), ptr_i (search start), idx_o (winner), found_o (any request set).
module axis_insert_header_arbiter_rr_select
    import axis_insert_header_arbiter_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    logic [MAX_SRC-1:0] req_ext;
    logic [2:0]         ptr_ext;
    logic [3:0]         pick;

    always_comb begin
        req_ext = MAX_SRC'(req_i);
        ptr_ext = 3'(ptr_i);
        pick    = rr_pick(req_ext, ptr_ext, N);
        idx_o   = W'(pick[2:0]);
        found_o = pick[3];
    end

endmodule

// File: rtl/axis_insert_header_arbiter.sv
// Round-robin arbiter feeding one header inserter: forwards the winner's header beat, then its payload to last.
// Latency: zero-cycle combinational forwarding on the registered grant; one idle cycle to re-arbitrate per packet.
// Backpressure: inserter readies are steered to the granted source only; all other sources see ready low.
// Ports: s_* per-source header/payload channels (source i at slice i), *_insert / *_in towards the
//        inserter, grant = owning source, busy = packet in flight, pkt_cnt = completed packets (wraps).
module axis_insert_header_arbiter
    import axis_insert_header_arbiter_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int NUM_SRC      = 2,
    parameter int SRC_WD       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_SRC-1:0]              s_valid_hdr,
    input  logic [NUM_SRC*DATA_WD-1:0]      s_header,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_hdr,
    output logic [NUM_SRC-1:0]              s_ready_hdr,
    input  logic [NUM_SRC-1:0]              s_valid,
    input  logic [NUM_SRC*DATA_WD-1:0]      s_data,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep,
    input  logic [NUM_SRC-1:0]              s_last,
    output logic [NUM_SRC-1:0]              s_ready,
    output logic                            valid_insert,
    output logic [DATA_WD-1:0]              header_insert,
    output logic [DATA_BYTE_WD-1:0]         keep_insert,
    input  logic                            ready_insert,
    output logic                            valid_in,
    output logic [DATA_WD-1:0]              data_in,
    output logic [DATA_BYTE_WD-1:0]         keep_in,
    output logic                            last_in,
    input  logic                            ready_in,
    output logic [SRC_WD-1:0]               grant,
    output logic                            busy,
    output logic [15:0]                     pkt_cnt
);

    logic [1:0]        state_q,   state_d;
    logic [SRC_WD-1:0] grant_q,   grant_d;
    logic [SRC_WD-1:0] rr_ptr_q,  rr_ptr_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;
    logic [SRC_WD-1:0] pick_idx;
    logic              pick_found;
    logic [SRC_WD-1:0] grant_next;

    axis_insert_header_arbiter_rr_select #(
        .N (NUM_SRC),
        .W (SRC_WD)
    ) u_rr_select (
        .req_i   (s_valid_hdr),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Pointer moves one past the source just served so it becomes lowest priority.
    assign grant_next = (grant_q == SRC_WD'(NUM_SRC - 1)) ? '0 : grant_q + SRC_WD'(1);

    // Forwarding muxes. Outputs are zeroed outside their own phase so the
    // inserter never sees stale data and no readies leak to a source.
    always_comb begin
        valid_insert  = 1'b0;
        header_insert = '0;
        keep_insert   = '0;
        s_ready_hdr   = '0;
        valid_in      = 1'b0;
        data_in       = '0;
        keep_in       = '0;
        last_in       = 1'b0;
        s_ready       = '0;
        if (state_q == ST_HDR) begin
            valid_insert         = s_valid_hdr[grant_q];
            header_insert        = s_header[grant_q*DATA_WD +: DATA_WD];
            keep_insert          = s_keep_hdr[grant_q*DATA_BYTE_WD +: DATA_BYTE_WD];
            s_ready_hdr[grant_q] = ready_insert;
        end
        if (state_q == ST_DATA) begin
            valid_in         = s_valid[grant_q];
            data_in          = s_data[grant_q*DATA_WD +: DATA_WD];
            keep_in          = s_keep[grant_q*DATA_BYTE_WD +: DATA_BYTE_WD];
            last_in          = s_last[grant_q];
            s_ready[grant_q] = ready_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                // Grant stays with this source even if its header valid drops.
                if (valid_insert && ready_insert) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (valid_in && ready_in && last_in) begin
                    state_d   = ST_IDLE;
                    rr_ptr_d  = grant_next;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q != ST_IDLE);
    assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_axis_insert_header_arbiter.sv
// Bench for the header-inserter arbiter: per-source packet queues drive the DUT, a transaction model checks it.
// Latency: n/a (testbench).
// Backpressure: ready_insert/ready_in driven constant, random or alternating depending on the step.
module tb_axis_insert_header_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int SW = 1;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    s_valid_hdr, s_ready_hdr, s_valid, s_last, s_ready;
    logic [N*DW-1:0] s_header, s_data;
    logic [N*KW-1:0] s_keep_hdr, s_keep;
    logic            valid_insert, ready_insert, valid_in, last_in, ready_in, busy;
    logic [DW-1:0]   header_insert, data_in;
    logic [KW-1:0]   keep_insert, keep_in;
    logic [SW-1:0]   grant;
    logic [15:0]     pkt_cnt;

    axis_insert_header_arbiter #(
        .DATA_WD (DW), .DATA_BYTE_WD (KW), .NUM_SRC (N), .SRC_WD (SW)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .s_valid_hdr (s_valid_hdr), .s_header (s_header), .s_keep_hdr (s_keep_hdr),
        .s_ready_hdr (s_ready_hdr),
        .s_valid (s_valid), .s_data (s_data), .s_keep (s_keep), .s_last (s_last),
        .s_ready (s_ready),
        .valid_insert (valid_insert), .header_insert (header_insert),
        .keep_insert (keep_insert), .ready_insert (ready_insert),
        .valid_in (valid_in), .data_in (data_in), .keep_in (keep_in),
        .last_in (last_in), .ready_in (ready_in),
        .grant (grant), .busy (busy), .pkt_cnt (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    // Source-side packet queues (what each requester still has to send).
    logic [31:0] hdr_q   [N][$];
    logic [3:0]  hkeep_q [N][$];
    beat_t       beat_q  [N][$];
    bit          hdr_vld [N];
    bit          pay_vld [N];
    bit          in_pkt  [N];

    // Reference model state: who owns the inserter and in which phase.
    int          owner;
    int          phase;
    int          m_ptr;
    logic [15:0] m_cnt;
    int          glog[$];
    int          hdr_cyc[$];
    int          last_cyc[$];
    int          cyc;
    int          data_hs;
    int          beats_in_pkt;
    int unsigned vprob;
    int          rmode_ins, rmode_in;
    int          n_tests, n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int s, input int nb, input logic [31:0] h,
                           input logic [3:0] hk, input logic [3:0] lk);
        beat_t b;
        hdr_q[s].push_back(h);
        hkeep_q[s].push_back(hk);
        for (int j = 0; j < nb; j++) begin
            b.data = $urandom;
            b.keep = (j == nb - 1) ? lk : 4'hF;
            b.last = (j == nb - 1);
            beat_q[s].push_back(b);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            hdr_q[i].delete();
            hkeep_q[i].delete();
            beat_q[i].delete();
            hdr_vld[i] = 0;
            pay_vld[i] = 0;
            in_pkt[i]  = 0;
        end
        owner = -1; phase = 0; m_ptr = 0; m_cnt = '0; beats_in_pkt = 0;
        glog.delete(); hdr_cyc.delete(); last_cyc.delete();
    endtask

    // Holds reset with all request inputs high to prove nothing leaks through.
    task automatic do_reset();
        rst_n        = 1'b0;
        s_valid_hdr  = '1;
        s_valid      = '1;
        s_last       = '1;
        s_header     = {$urandom, $urandom};
        s_data       = {$urandom, $urandom};
        s_keep_hdr   = 8'hFF;
        s_keep       = 8'hFF;
        ready_insert = 1'b1;
        ready_in     = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_valid_insert", valid_insert, 0);
        chk("rst_valid_in", valid_in, 0);
        chk("rst_ready_hdr", s_ready_hdr, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_data_in", {data_in, keep_in, last_in}, 0);
        chk("rst_header_insert", {header_insert, keep_insert}, 0);
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive sources at the negedge, check outputs, advance the model by
    // whatever handshakes the next posedge will perform.
    task automatic step();
        logic [N-1:0] er;
        beat_t        b;
        for (int i = 0; i < N; i++) begin
            if (!hdr_vld[i] && !in_pkt[i] && hdr_q[i].size() > 0 && $urandom_range(99) < vprob)
                hdr_vld[i] = 1;
            if (!pay_vld[i] && beat_q[i].size() > 0 && (in_pkt[i] || hdr_vld[i]) &&
                $urandom_range(99) < vprob)
                pay_vld[i] = 1;
            s_valid_hdr[i] = hdr_vld[i];
            s_valid[i]     = pay_vld[i];
            if (hdr_vld[i]) begin
                s_header[i*DW +: DW]   = hdr_q[i][0];
                s_keep_hdr[i*KW +: KW] = hkeep_q[i][0];
            end else begin
                s_header[i*DW +: DW]   = $urandom;
                s_keep_hdr[i*KW +: KW] = 4'($urandom);
            end
            if (pay_vld[i]) begin
                s_data[i*DW +: DW] = beat_q[i][0].data;
                s_keep[i*KW +: KW] = beat_q[i][0].keep;
                s_last[i]          = beat_q[i][0].last;
            end else begin
                s_data[i*DW +: DW] = $urandom;
                s_keep[i*KW +: KW] = 4'($urandom);
                s_last[i]          = 1'($urandom_range(1));
            end
        end
        ready_insert = (rmode_ins == 0) ? 1'b1 : 1'($urandom_range(1));
        if (rmode_in == 0)      ready_in = 1'b1;
        else if (rmode_in == 1) ready_in = 1'($urandom_range(1));
        else                    ready_in = ~ready_in;
        #1;
        chk("busy", busy, (owner >= 0));
        chk("pkt_cnt", pkt_cnt, m_cnt);
        if (owner < 0) begin
            chk("idle_valid_insert", valid_insert, 0);
            chk("idle_valid_in", valid_in, 0);
            chk("idle_ready_hdr", s_ready_hdr, 0);
            chk("idle_ready", s_ready, 0);
            for (int k = 0; k < N; k++) begin
                if (owner < 0 && hdr_vld[(m_ptr + k) % N]) begin
                    owner = (m_ptr + k) % N;
                    phase = 0;
                    glog.push_back(owner);
                end
            end
        end else if (phase == 0) begin
            er = '0;
            er[owner] = ready_insert;
            chk("hdr_grant", grant, owner);
            chk("hdr_valid_insert", valid_insert, hdr_vld[owner]);
            chk("hdr_ready_hdr", s_ready_hdr, er);
            chk("hdr_ready_stalled", s_ready, 0);
            chk("hdr_valid_in", valid_in, 0);
            if (hdr_vld[owner]) begin
                chk("hdr_header", header_insert, hdr_q[owner][0]);
                chk("hdr_keep", keep_insert, hkeep_q[owner][0]);
                if (ready_insert) begin
                    hdr_cyc.push_back(cyc);
                    void'(hdr_q[owner].pop_front());
                    void'(hkeep_q[owner].pop_front());
                    hdr_vld[owner] = 0;
                    in_pkt[owner]  = 1;
                    phase = 1;
                end
            end
        end else begin
            er = '0;
            er[owner] = ready_in;
            chk("data_grant", grant, owner);
            chk("data_valid_in", valid_in, pay_vld[owner]);
            chk("data_ready", s_ready, er);
            chk("data_ready_hdr", s_ready_hdr, 0);
            chk("data_valid_insert", valid_insert, 0);
            if (pay_vld[owner]) begin
                chk("data_beat", {data_in, keep_in, last_in}, beat_q[owner][0]);
                if (ready_in) begin
                    b = beat_q[owner].pop_front();
                    pay_vld[owner] = 0;
                    data_hs++;
                    beats_in_pkt++;
                    if (b.last) begin
                        in_pkt[owner] = 0;
                        last_cyc.push_back(cyc);
                        m_ptr = (owner + 1) % N;
                        m_cnt = m_cnt + 16'd1;
                        owner = -1;
                        beats_in_pkt = 0;
                    end
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget);
        bit done;
        int n;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            done = (owner < 0);
            for (int i = 0; i < N; i++)
                if (hdr_q[i].size() != 0 || beat_q[i].size() != 0) done = 0;
            if (!done) begin
                step();
                n++;
            end
        end
        chk(tag, done, 1);
    endtask

    initial begin
        int t0, h0;
        int exp_fair[5];
        logic [15:0] c0;
        n_tests = 0; n_fail = 0; cyc = 0; data_hs = 0;
        vprob = 100; rmode_ins = 0; rmode_in = 0;
        s_valid_hdr = '0; s_valid = '0; s_last = '0;
        s_header = '0; s_data = '0; s_keep_hdr = '0; s_keep = '0;
        ready_insert = 1'b0; ready_in = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);

        // Single source, fixed header, 3 beats ending in keep 1100.
        do_reset();
        add_pkt(0, 3, 32'hA5A5A5A5, 4'b0011, 4'b1100);
        t0 = cyc;
        drain("t1_drain", 50);
        chk("t1_hdr_hs_second_cycle", (hdr_cyc.size() > 0) ? hdr_cyc[0] - t0 : -1, 1);
        chk("t1_grant_count", glog.size(), 1);
        chk("t1_grant0", (glog.size() > 0) ? glog[0] : -1, 0);
        chk("t1_pkt_cnt", pkt_cnt, 1);
        #1;
        chk("t1_busy_after_last", busy, 0);
        @(negedge clk);

        // Both sources from reset; source 1 also presents payload while source 0 owns.
        do_reset();
        add_pkt(0, 3, $urandom, 4'b1111, 4'b0001);
        add_pkt(1, 2, $urandom, 4'b0111, 4'b0011);
        drain("t2_drain", 50);
        chk("t2_grant_count", glog.size(), 2);
        chk("t2_first_src0", (glog.size() > 0) ? glog[0] : -1, 0);
        chk("t2_second_src1", (glog.size() > 1) ? glog[1] : -1, 1);
        chk("t2_one_idle_gap",
            (hdr_cyc.size() > 1 && last_cyc.size() > 0) ? hdr_cyc[1] - last_cyc[0] : -1, 2);
        chk("t2_pkt_cnt", pkt_cnt, 2);

        // Backpressure: ready_in alternates 1,0,1,0 during a 4-beat packet.
        ready_in = 1'b0;
        rmode_in = 2;
        add_pkt(0, 4, $urandom, 4'b1111, 4'b1111);
        h0 = data_hs;
        drain("t4_drain", 50);
        chk("t4_handshakes", data_hs - h0, 4);
        rmode_in = 0;

        // Abort source 1 mid-packet with an asynchronous reset after its 2nd beat.
        add_pkt(1, 4, $urandom, 4'b1111, 4'b1111);
        h0 = 0;
        while (!(owner == 1 && beats_in_pkt == 2) && h0 < 50) begin
            step();
            h0++;
        end
        chk("t5_reached_beat2", (owner == 1 && beats_in_pkt == 2), 1);
        chk("t5_grant_before_rst", grant, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid_in_drop", valid_in, 0);
        chk("t5_valid_insert_drop", valid_insert, 0);
        chk("t5_grant_rst", grant, 0);
        chk("t5_pkt_cnt_rst", pkt_cnt, 0);
        do_reset();
        add_pkt(1, 2, $urandom, 4'b0011, 4'b0001);
        drain("t5_drain", 50);
        chk("t5_regrant", (glog.size() > 0) ? glog[0] : -1, 1);
        chk("t5_pkt_cnt", pkt_cnt, 1);

        // Fairness: source 0 back-to-back 1-beat packets, source 1 one packet.
        do_reset();
        for (int p = 0; p < 4; p++) add_pkt(0, 1, $urandom, 4'b1111, 4'b1111);
        add_pkt(1, 1, $urandom, 4'b1111, 4'b0011);
        drain("t6_drain", 80);
        exp_fair = '{0, 1, 0, 0, 0};
        chk("t6_grant_count", glog.size(), 5);
        for (int g = 0; g < 5; g++)
            chk($sformatf("t6_grant_seq%0d", g), (glog.size() > g) ? glog[g] : -1, exp_fair[g]);

        // Random traffic on both sources with random readies.
        vprob = 60; rmode_ins = 1; rmode_in = 1;
        c0 = m_cnt;
        for (int p = 0; p < 20; p++)
            for (int s = 0; s < N; s++)
                add_pkt(s, int'($urandom_range(1, 5)), $urandom, 4'($urandom), 4'($urandom));
        drain("t7_drain", 4000);
        chk("t7_pkt_cnt", pkt_cnt, c0 + 16'd40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
